// File: rtl/dmem_access_seq_if.sv
// Data-memory bus between the access sequencer (master) and the memory (slave).
// mem_ready_n is active-low; mem_rdata is valid only while mem_ready_n is low.
interface dmem_access_seq_if;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_ready_n;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_write, mem_addr, mem_size, mem_wdata,
    input  mem_ready_n, mem_rdata
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_size, mem_wdata,
    output mem_ready_n, mem_rdata
  );
endinterface

// File: rtl/dmem_access_seq.sv
// Sequences one data-memory transaction per MEM-stage load/store: size/alignment check,
// bus drive with ready_n handshake and timeout, store lane steering, load extraction.
module dmem_access_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  input  logic                     is_store_i,
  input  logic [2:0]               funct3_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  dmem_access_seq_if.master        mem,
  output logic                     stall_o,
  output logic                     done_o,
  output logic                     fault_o,
  output logic [1:0]               fault_cause_o,
  output logic [31:0]              load_data_o
);

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_e;

  state_e             state_q;
  logic               mem_req_q;
  logic               mem_write_q;
  logic [31:0]        mem_addr_q;
  logic [1:0]         mem_size_q;
  logic [31:0]        mem_wdata_q;
  logic [2:0]         funct3_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic               fault_q;
  logic [1:0]         fault_cause_q;
  logic [31:0]        load_data_q;

  logic               illegal_d;
  logic               misaligned_d;
  logic [1:0]         size_d;
  logic [31:0]        wdata_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [7:0]         rbyte_d;
  logic [15:0]        rhalf_d;
  logic [31:0]        load_d;

  // Request decode: legality, alignment, bus size and lane-replicated store data
  always_comb begin
    illegal_d    = 1'b0;
    misaligned_d = 1'b0;
    size_d       = SIZE_NONE;
    wdata_d      = wdata_i;
    if (is_store_i) begin
      illegal_d = funct3_i[2] || (funct3_i[1:0] == 2'b11);
    end else begin
      illegal_d = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110);
    end
    case (funct3_i[1:0])
      2'b00: begin
        size_d  = SIZE_BYTE;
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        size_d       = SIZE_HALF;
        wdata_d      = {2{wdata_i[15:0]}};
        misaligned_d = addr_i[0];
      end
      2'b10: begin
        size_d       = SIZE_WORD;
        misaligned_d = (addr_i[1:0] != 2'b00);
      end
      default: begin
        size_d = SIZE_NONE;
      end
    endcase
  end

  // Load lane extraction from the latched address, then sign/zero extension
  always_comb begin
    rbyte_d = mem.mem_rdata[7:0];
    case (mem_addr_q[1:0])
      2'b00:   rbyte_d = mem.mem_rdata[7:0];
      2'b01:   rbyte_d = mem.mem_rdata[15:8];
      2'b10:   rbyte_d = mem.mem_rdata[23:16];
      default: rbyte_d = mem.mem_rdata[31:24];
    endcase
    rhalf_d = mem_addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_d = {{24{~funct3_q[2] & rbyte_d[7]}}, rbyte_d};
      2'b01:   load_d = {{16{~funct3_q[2] & rhalf_d[15]}}, rhalf_d};
      default: load_d = mem.mem_rdata;
    endcase
  end

  assign cnt_d   = cnt_q + CNT_W'(1);
  assign stall_o = (state_q == S_ACCESS) || ((state_q == S_IDLE) && req_valid_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_size_q    <= SIZE_NONE;
      mem_wdata_q   <= 32'd0;
      funct3_q      <= 3'd0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      load_data_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            if (illegal_d || misaligned_d) begin
              state_q       <= S_DONE;
              done_q        <= 1'b1;
              fault_q       <= 1'b1;
              fault_cause_q <= illegal_d ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            end else begin
              state_q     <= S_ACCESS;
              mem_req_q   <= 1'b1;
              mem_write_q <= is_store_i;
              mem_addr_q  <= addr_i;
              mem_size_q  <= size_d;
              mem_wdata_q <= wdata_d;
              funct3_q    <= funct3_i;
              cnt_q       <= '0;
            end
          end
        end
        S_ACCESS: begin
          // A ready in the timeout cycle still completes successfully
          if (!mem.mem_ready_n) begin
            state_q       <= S_DONE;
            mem_req_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_size_q    <= SIZE_NONE;
            done_q        <= 1'b1;
            fault_q       <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
            if (!mem_write_q) begin
              load_data_q <= load_d;
            end
          end else begin
            cnt_q <= cnt_d;
            if (TIMEOUT_EN && (cnt_d == TIMEOUT_CNT)) begin
              state_q       <= S_DONE;
              mem_req_q     <= 1'b0;
              mem_write_q   <= 1'b0;
              mem_size_q    <= SIZE_NONE;
              done_q        <= 1'b1;
              fault_q       <= 1'b1;
              fault_cause_q <= CAUSE_TIMEOUT;
            end
          end
        end
        S_DONE: begin
          state_q       <= S_IDLE;
          done_q        <= 1'b0;
          fault_q       <= 1'b0;
          fault_cause_q <= CAUSE_NONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_write = mem_write_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_size  = mem_size_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign done_o        = done_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = fault_cause_q;
  assign load_data_o   = load_data_q;

endmodule
